// File: rtl/uart_rx_frame_parser.sv
// Sync-hunting, length-prefixed, XOR-checked frame parser for a UART byte stream.
// Optional inter-byte timeout is enabled by defining UART_RX_FRAME_TIMEOUT_EN.
module uart_rx_frame_parser #(
  parameter int unsigned MAX_LEN     = 16,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_ready,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code
);

  localparam int unsigned LW = $clog2(MAX_LEN + 1);
  localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MaxLenByte = 8'(MAX_LEN);

  typedef enum logic [2:0] {StHunt, StLen, StPayload, StChk, StDrain} state_e;

  state_e        state_q;
  logic [LW-1:0] len_q, idx_q, rd_q;
  logic [7:0]    chk_acc_q;
  logic [7:0]    buffer [MAX_LEN];

  logic [LW-1:0] len_m1, rd_nxt;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [7:0]    rd_byte;
  logic          tmo_hit;

  assign len_m1  = len_q - LW'(1);
  assign rd_nxt  = rd_q + LW'(1);
  assign wr_addr = idx_q[AW-1:0];
  // Outside DRAIN the read port prefetches entry 0 for the first beat.
  assign rd_addr = (state_q == StDrain) ? rd_nxt[AW-1:0] : '0;
  assign rd_byte = buffer[rd_addr];

  // Payload storage needs no reset; contents are only read after being written.
  always_ff @(posedge clk) begin
    if (state_q == StPayload && rx_valid) begin
      buffer[wr_addr] <= rx_data;
    end
  end

`ifdef UART_RX_FRAME_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] tmo_q;
  logic          timed;

  assign timed   = (state_q == StLen) || (state_q == StPayload) || (state_q == StChk);
  assign tmo_hit = timed && !rx_valid && (tmo_q == TmoLast);

  // Every entry into a timed state happens on rx_valid, so clearing on rx_valid covers entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_q <= '0;
    end else if (rx_valid || !timed || tmo_hit) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + TW'(1);
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StHunt;
      len_q     <= '0;
      idx_q     <= '0;
      rd_q      <= '0;
      chk_acc_q <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= '0;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      unique case (state_q)
        StHunt: begin
          if (rx_valid && rx_data == SYNC_BYTE) begin
            state_q <= StLen;
          end
        end
        StLen: begin
          if (rx_valid) begin
            len_q     <= LW'(rx_data);
            chk_acc_q <= rx_data;
            idx_q     <= '0;
            if (rx_data == 8'd0 || rx_data > MaxLenByte) begin
              frame_err <= 1'b1;
              err_code  <= 2'b01;
              state_q   <= StHunt;
            end else begin
              state_q <= StPayload;
            end
          end
        end
        StPayload: begin
          if (rx_valid) begin
            chk_acc_q <= chk_acc_q ^ rx_data;
            idx_q     <= idx_q + LW'(1);
            if (idx_q == len_m1) begin
              state_q <= StChk;
            end
          end
        end
        StChk: begin
          if (rx_valid) begin
            if (rx_data == chk_acc_q) begin
              frame_ok  <= 1'b1;
              rd_q      <= '0;
              out_valid <= 1'b1;
              out_data  <= rd_byte;
              out_last  <= (len_q == LW'(1));
              state_q   <= StDrain;
            end else begin
              frame_err <= 1'b1;
              err_code  <= 2'b10;
              state_q   <= StHunt;
            end
          end
        end
        StDrain: begin
          // Bytes arriving while draining are dropped, even on the final beat.
          if (rx_valid) begin
            frame_err <= 1'b1;
            err_code  <= 2'b11;
          end
          if (out_valid && out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_data  <= '0;
              state_q   <= StHunt;
            end else begin
              rd_q     <= rd_nxt;
              out_data <= rd_byte;
              out_last <= (rd_nxt == len_m1);
            end
          end
        end
        default: state_q <= StHunt;
      endcase
      if (tmo_hit) begin
        frame_err <= 1'b1;
        err_code  <= 2'b11;
        state_q   <= StHunt;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Scoreboard bench for uart_rx_frame_parser: stimulus pushes expected beats/events,
// a negedge monitor pops and compares them.
module tb_uart_rx_frame_parser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       out_ready = 1'b1;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;

  int total = 0;
  int bad = 0;

  localparam logic [2:0] EvOk = 3'b100;
  localparam logic [2:0] EvLen = 3'b001;
  localparam logic [2:0] EvChk = 3'b010;
  localparam logic [2:0] EvOvr = 3'b011;

  logic [8:0] exp_out[$];
  logic [2:0] exp_ev[$];

  uart_rx_frame_parser #(
    .MAX_LEN(16),
    .SYNC_BYTE(8'hA5),
    .TIMEOUT_CYC(50)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_last(out_last),
    .out_ready(out_ready),
    .frame_ok(frame_ok),
    .frame_err(frame_err),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares every event pulse and every accepted beat against the queues.
  always @(negedge clk) begin
    if (rst) begin
      if (frame_ok || frame_err) begin
        logic [2:0] got;
        got = (frame_ok && frame_err) ? 3'b111 : (frame_ok ? EvOk : {1'b0, err_code});
        if (exp_ev.size() == 0) chk("unexpected_event", 16'(got), 16'h0);
        else chk("event", 16'(got), 16'(exp_ev.pop_front()));
      end
      if (out_valid && out_ready) begin
        if (exp_out.size() == 0) chk("unexpected_beat", {7'd0, out_last, out_data}, 16'hFFFF);
        else chk("beat", {7'd0, out_last, out_data}, 16'(exp_out.pop_front()));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step(1);
    rx_valid = 1'b0;
    rx_data  = '0;
  endtask

  task automatic expect_good3();
    exp_ev.push_back(EvOk);
    exp_out.push_back({1'b0, 8'h11});
    exp_out.push_back({1'b0, 8'h22});
    exp_out.push_back({1'b1, 8'h33});
  endtask

  task automatic send_good3();
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h03);
  endtask

  task automatic wait_drained(input string name);
    for (int i = 0; i < 100 && exp_out.size() != 0; i++) step(1);
    step(3);
    chk(name, 16'(exp_out.size() + exp_ev.size()), 16'd0);
  endtask

  task automatic check_zero_outputs(input string name);
    chk(name, {4'd0, out_valid, out_last, frame_ok, frame_err, out_data}, 16'd0);
  endtask

  initial begin
    #2 rst = 1'b0;
    #1;
    chk("rst_out_data", 16'(out_data), 16'h0);
    chk("rst_out_valid", 16'(out_valid), 16'h0);
    chk("rst_out_last", 16'(out_last), 16'h0);
    chk("rst_frame_ok", 16'(frame_ok), 16'h0);
    chk("rst_frame_err", 16'(frame_err), 16'h0);
    chk("rst_err_code", 16'(err_code), 16'h0);
    step(2);
    rst = 1'b1;
    step(1);

    // Good frame after noise, with cycle-exact latency and back-to-back beats.
    send(8'h00); send(8'hFF);
    expect_good3();
    send_good3();
    chk("good_first", {5'd0, frame_ok, out_valid, out_last, out_data}, {5'd0, 3'b110, 8'h11});
    step(1);
    chk("good_second", {5'd0, frame_ok, out_valid, out_last, out_data}, {5'd0, 3'b010, 8'h22});
    step(1);
    chk("good_third", {5'd0, frame_ok, out_valid, out_last, out_data}, {5'd0, 3'b011, 8'h33});
    step(1);
    chk("good_done", 16'(out_valid), 16'h0);
    wait_drained("good_drained");

    // Bad checksum (expected FD), then a good frame.
    exp_ev.push_back(EvChk);
    send(8'hA5); send(8'h02); send(8'hAA); send(8'h55); send(8'h00);
    step(1);
    chk("badchk_no_valid", 16'(out_valid), 16'h0);
    chk("badchk_code", 16'(err_code), 16'(2'b10));
    expect_good3();
    send_good3();
    wait_drained("badchk_drained");

    // Zero and oversize lengths, each followed by a return to hunting.
    exp_ev.push_back(EvLen);
    send(8'hA5); send(8'h00);
    exp_ev.push_back(EvLen);
    send(8'hA5); send(8'h11);
    step(1);
    chk("badlen_code", 16'(err_code), 16'(2'b01));
    expect_good3();
    send_good3();
    wait_drained("badlen_drained");

    // Backpressure with an overrun byte mid-drain.
    out_ready = 1'b0;
    expect_good3();
    send_good3();
    step(3);
    exp_ev.push_back(EvOvr);
    send(8'h77);
    step(6);
    chk("bp_hold", {5'd0, frame_err, out_valid, out_last, out_data}, {5'd0, 3'b010, 8'h11});
    chk("bp_code", 16'(err_code), 16'(2'b11));
    out_ready = 1'b1;
    wait_drained("bp_drained");

    // Overrun byte coincides with the final beat; a sync value there must not start a frame.
    out_ready = 1'b0;
    expect_good3();
    send_good3();
    step(2);
    out_ready = 1'b1;
    step(2);
    exp_ev.push_back(EvOvr);
    send(8'hA5);
    step(1);
    expect_good3();
    send_good3();
    wait_drained("simul_drained");

    // Reset while draining.
    out_ready = 1'b0;
    exp_ev.push_back(EvOk);
    send_good3();
    step(2);
    chk("rstdrain_pre", {7'd0, out_valid, out_data}, {7'd0, 1'b1, 8'h11});
    rst = 1'b0;
    #1;
    check_zero_outputs("rstdrain_zero");
    step(2);
    rst = 1'b1;
    out_ready = 1'b1;
    step(2);
    chk("rstdrain_idle", 16'(out_valid), 16'h0);

    // Reset mid-payload, then a clean frame.
    send(8'hA5); send(8'h03); send(8'h11);
    rst = 1'b0;
    #1;
    check_zero_outputs("rstmid_zero");
    step(2);
    rst = 1'b1;
    step(1);
    expect_good3();
    send_good3();
    wait_drained("rstmid_drained");

    // Inter-byte stall.
`ifdef UART_RX_FRAME_TIMEOUT_EN
    exp_ev.push_back(EvOvr);
    send(8'hA5); send(8'h03); send(8'h11);
    step(60);
    chk("tmo_code", 16'(err_code), 16'(2'b11));
    expect_good3();
    send_good3();
`else
    expect_good3();
    send(8'hA5); send(8'h03); send(8'h11);
    step(60);
    chk("stall_no_err", 16'(frame_err), 16'h0);
    send(8'h22); send(8'h33); send(8'h03);
`endif
    wait_drained("stall_drained");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/uart_rx_frame_parser.md
Name: uart_rx_frame_parser

Overview:
- Sits directly downstream of the UART receiver and consumes its byte stream.
- Hunts for a sync byte, then collects a length-prefixed payload into an internal buffer and checks an XOR checksum.
- Releases the payload on a valid/ready stream only if the checksum matches; bad frames are dropped and reported.
- Protects the bus-side consumer from ever seeing a corrupt frame.

Parameters:
- MAX_LEN, 16, maximum payload bytes per frame (buffer depth); legal range 1..255.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYC, 100000, inter-byte timeout in clk cycles (used only when the optional feature is compiled in).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- rx_data  input  8  received byte from the UART receiver.
- rx_valid  input  1  one-cycle strobe, rx_data valid; at most one byte per cycle.
- out_data  output  8  payload byte.
- out_valid  output  1  out_data valid.
- out_last  output  1  marks the final payload byte of a frame.
- out_ready  input  1  consumer accepts; a transfer occurs when out_valid && out_ready.
- frame_ok  output  1  one-cycle pulse, good frame accepted.
- frame_err  output  1  one-cycle pulse, frame rejected or byte dropped.
- err_code  output  2  cause, valid with frame_err: 01 bad length, 10 bad checksum, 11 overrun/timeout.

Behaviour:
- Clock and reset:
  - Single clk domain.
  - rst low asynchronously clears all state.
  - Outputs at reset: out_data=0, out_valid=0, out_last=0, frame_ok=0, frame_err=0, err_code=0; FSM=HUNT; buffer contents don't-care.
- Frame format: SYNC_BYTE, LEN, LEN payload bytes, CHK.
  - CHK = LEN ^ payload[0] ^ ... ^ payload[LEN-1].
- FSM states:
  - HUNT: on rx_valid with rx_data==SYNC_BYTE go to LEN; other bytes are ignored silently, no error.
  - LEN: on rx_valid latch len=rx_data and set chk_acc=rx_data.
    - If rx_data==0 or rx_data>MAX_LEN: frame_err pulse, err_code=01, go to HUNT.
    - Otherwise clear the write index and go to PAYLOAD.
  - PAYLOAD: on rx_valid write buf[idx]=rx_data, chk_acc^=rx_data, idx++.
    - After the byte with idx==len-1, go to CHK.
    - A byte equal to SYNC_BYTE inside the payload is data, not a resync.
  - CHK: on rx_valid compare rx_data with chk_acc.
    - Match: frame_ok pulse in the next cycle, rd index=0, go to DRAIN.
    - Mismatch: frame_err pulse, err_code=10, go to HUNT.
  - DRAIN:
    - out_valid=1, out_data=buf[rd]; out_last=1 when rd==len-1.
    - Each transfer increments rd.
    - The transfer with out_last returns to HUNT in the next cycle, with out_valid=0.
- Latency: frame_ok and the first out_valid assert in the cycle after the clk edge that samples the CHK byte.
- Backpressure: while out_ready=0, out_data, out_last and out_valid hold stable; no timeout applies in DRAIN.
- Overrun: rx_valid during DRAIN drops the byte and pulses frame_err with err_code=11; the drain continues unaffected.
- Simultaneous events: a dropped rx byte and a final out_last transfer in the same cycle still count as an overrun; the byte is not re-examined in HUNT.
- Error pulses: err_code holds its value until the next frame_err; frame_ok and frame_err never assert in the same cycle.
- Width rules: idx, rd and len use $clog2(MAX_LEN+1) bits; chk_acc is 8 bits with XOR wrap, no carry.
- Reset mid-frame (any state, including DRAIN):
  - Immediately deasserts out_valid and discards buffered data.
  - No frame_ok or frame_err is produced for the aborted frame.

Optional Feature:
- Macro: UART_RX_FRAME_TIMEOUT_EN.
- Defined:
  - An inter-byte counter runs in LEN, PAYLOAD and CHK; it is cleared on each rx_valid and on state entry.
  - When it reaches TIMEOUT_CYC-1 with no rx_valid: frame_err pulse, err_code=11, go to HUNT.
  - If rx_valid arrives in that same cycle, the byte wins and there is no timeout.
- Undefined:
  - No counter logic is present; a stalled frame waits indefinitely.
  - err_code=11 means overrun only.

Test Plan:
- Good frame: bytes A5 03 11 22 33 03 with out_ready=1 -> frame_ok pulse once; out_data 11,22,33 on consecutive cycles; out_last only with 33; frame_err never asserts.
- Bad checksum: A5 02 AA 55 00 (expected CHK FD) -> frame_err pulse with err_code=10; no out_valid; the following good frame from the first scenario is accepted.
- Bad length: A5 00, then A5 11 with MAX_LEN=16 -> two frame_err pulses with err_code=01; FSM back in HUNT each time; leading noise bytes 00 FF before A5 cause no error.
- Backpressure and overrun: good 3-byte frame, out_ready held 0 for 10 cycles, rx_valid with byte 77 during DRAIN -> out_data holds 11 stable; frame_err with err_code=11; after out_ready=1 the payload 11,22,33 is delivered intact.
- Reset mid-frame: assert rst low after A5 03 11 -> all outputs 0 immediately; after release, a full good frame is parsed normally.
- Timeout (macro defined, TIMEOUT_CYC=50): send A5 03 11, then idle 50 cycles -> frame_err with err_code=11 at cycle 50; without the macro, no error and the frame completes when the remaining bytes arrive.
